pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter: PC_W, 32, instruction address width.
REQ-002 Parameter: INST_W, 32, instruction word width.
REQ-003 Parameter: NOP_PC, 0, address value driven on dn_pc_o when no valid entry is presented.
REQ-004 Parameter: NOP_INST, 32'h00000013, instruction value driven on dn_inst_o when no valid entry is presented.
REQ-005 Port: clk  input  1  clock; all state updates on rising edge.
REQ-006 Port: rst  input  1  reset, synchronous, active-high.
REQ-007 Port: flush_i  input  1  discard all held and incoming entries (branch/jump redirect).
REQ-008 Port: hold_i  input  1  downstream stall; freezes presented entry.
REQ-009 Port: up_valid_i  input  1  upstream (fetch) offers an entry.
REQ-010 Port: up_ready_o  output  1  stage can accept an entry this cycle.
REQ-011 Port: up_pc_i  input  PC_W  fetched instruction address.
REQ-012 Port: up_inst_i  input  INST_W  fetched instruction.
REQ-013 Port: dn_valid_o  output  1  entry presented to decode.
REQ-014 Port: dn_ready_i  input  1  decode consumes the presented entry.
REQ-015 Port: dn_pc_o  output  PC_W  presented address.
REQ-016 Port: dn_inst_o  output  INST_W  presented instruction.
REQ-017 Port: occupancy_o  output  2  number of held entries, 0..2.

Function
REQ-018 Storage SHALL be two entries: main register (presented) and skid register; state EMPTY/ONE/TWO, occupancy_o = 0/1/2 respectively.
REQ-019 push = up_valid_i & up_ready_o; pop = dn_valid_o & dn_ready_i & !hold_i.
REQ-020 up_ready_o SHALL be 1 in EMPTY and ONE, 0 in TWO; it SHALL depend only on registered state, not on dn_ready_i or hold_i.
REQ-021 dn_valid_o SHALL be 1 iff state != EMPTY; dn_pc_o/dn_inst_o SHALL equal main register when dn_valid_o=1, else NOP_PC/NOP_INST.
REQ-022 EMPTY: push -> ONE, main <= input; otherwise stay.
REQ-023 ONE: push & !pop -> TWO, skid <= input; push & pop -> ONE, main <= input; !push & pop -> EMPTY; neither -> stay, main unchanged.
REQ-024 TWO: pop -> ONE, main <= skid; no pop -> stay, both registers unchanged.
REQ-025 Latency: an entry pushed in cycle N SHALL be presented no earlier than cycle N+1; entries SHALL exit in push order; no entry is duplicated or lost except by flush.
REQ-026 hold_i=1 SHALL block pop only; push still permitted while up_ready_o=1.
REQ-027 flush_i=1 SHALL force state EMPTY at next edge, discarding main, skid and any same-cycle push; flush overrides hold_i, push and pop.
REQ-028 Outputs SHALL be stable while dn_valid_o=1 and no pop occurs (hold or dn_ready_i=0).
REQ-029 up_valid_i while up_ready_o=0 SHALL be ignored without state change; upstream holds its entry.

Reset
REQ-030 rst=1 at a rising edge SHALL force state EMPTY: up_ready_o=1, dn_valid_o=0, dn_pc_o=NOP_PC, dn_inst_o=NOP_INST, occupancy_o=0.
REQ-031 rst SHALL take priority over flush_i, hold_i and any handshake; reset mid-operation discards all entries.

Verification
REQ-032 Streaming: dn_ready_i=1 constantly, push PCs 0x0,0x4,0x8 on consecutive cycles -> decode sees 0x0,0x4,0x8 one cycle later each, occupancy_o stays 1, up_ready_o stays 1.
REQ-033 Back-pressure: hold_i=1, push 0x10 then 0x14 -> occupancy_o=2, up_ready_o=0, dn_pc_o=0x10 frozen; release hold -> 0x10 then 0x14 exit in order, up_ready_o returns 1.
REQ-034 Flush: state TWO plus up_valid_i=1 with flush_i=1 and hold_i=1 -> next cycle dn_valid_o=0, dn_inst_o=0x00000013, occupancy_o=0, flushed entries never appear.
REQ-035 Simultaneous push/pop in ONE: main=0x20, push 0x24 with pop -> next cycle dn_pc_o=0x24, occupancy_o=1.
REQ-036 Reset mid-operation: occupancy 2, assert rst one cycle -> outputs NOP_PC/NOP_INST, dn_valid_o=0, up_ready_o=1; first push after release appears next cycle.
REQ-037 Random: constrained-random up_valid_i/dn_ready_i/hold_i/flush_i against a scoreboard queue model -> ordering, no loss/duplication, occupancy_o matches model every cycle.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Two-entry skid buffer between instruction fetch and decode. The main
// register holds the entry presented to decode; the skid register catches a
// second entry when decode stalls. This lets up_ready_o be driven purely from
// registered state, so it never combinationally depends on dn_ready_i or
// hold_i.
//
// Every output comes straight from a flop. The main register is loaded with
// NOP_PC/NOP_INST whenever the buffer empties, so the NOP substitution needs
// no output mux.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   flush_i      in   drop held and incoming entries (redirect)
//   hold_i       in   downstream stall, blocks pop only
//   up_valid_i   in   fetch offers an entry
//   up_ready_o   out  buffer can accept an entry this cycle
//   up_pc_i      in   fetched address
//   up_inst_i    in   fetched instruction
//   dn_valid_o   out  entry presented to decode
//   dn_ready_i   in   decode consumes the presented entry
//   dn_pc_o      out  presented address (NOP_PC when not valid)
//   dn_inst_o    out  presented instruction (NOP_INST when not valid)
//   occupancy_o  out  number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int                 PC_W     = 32,
    parameter int                 INST_W   = 32,
    parameter logic [PC_W-1:0]    NOP_PC   = '0,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [PC_W-1:0]   up_pc_i,
    input  logic [INST_W-1:0] up_inst_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [PC_W-1:0]   dn_pc_o,
    output logic [INST_W-1:0] dn_inst_o,
    output logic [1:0]        occupancy_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q;
    logic [PC_W-1:0]     main_pc_q;
    logic [INST_W-1:0]   main_inst_q;
    logic [PC_W-1:0]     skid_pc_q;
    logic [INST_W-1:0]   skid_inst_q;
    logic                up_ready_q;
    logic                dn_valid_q;
    logic [1:0]          occ_q;

    logic push;
    logic pop;

    assign push = up_valid_i & up_ready_q;
    assign pop  = dn_valid_q & dn_ready_i & ~hold_i;

    always_ff @(posedge clk) begin
        // rst and flush have the same effect; rst simply outranks everything.
        if (rst || flush_i) begin
            state_q     <= ST_EMPTY;
            main_pc_q   <= NOP_PC;
            main_inst_q <= NOP_INST;
            skid_pc_q   <= NOP_PC;
            skid_inst_q <= NOP_INST;
            up_ready_q  <= 1'b1;
            dn_valid_q  <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_q     <= ST_ONE;
                        main_pc_q   <= up_pc_i;
                        main_inst_q <= up_inst_i;
                        dn_valid_q  <= 1'b1;
                        occ_q       <= 2'd1;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_q     <= ST_TWO;
                        skid_pc_q   <= up_pc_i;
                        skid_inst_q <= up_inst_i;
                        up_ready_q  <= 1'b0;
                        occ_q       <= 2'd2;
                    end else if (push && pop) begin
                        main_pc_q   <= up_pc_i;
                        main_inst_q <= up_inst_i;
                    end else if (pop) begin
                        state_q     <= ST_EMPTY;
                        main_pc_q   <= NOP_PC;
                        main_inst_q <= NOP_INST;
                        dn_valid_q  <= 1'b0;
                        occ_q       <= 2'd0;
                    end
                end
                ST_TWO: begin
                    // up_ready_o is low here, so push cannot occur.
                    if (pop) begin
                        state_q     <= ST_ONE;
                        main_pc_q   <= skid_pc_q;
                        main_inst_q <= skid_inst_q;
                        up_ready_q  <= 1'b1;
                        occ_q       <= 2'd1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    main_pc_q   <= NOP_PC;
                    main_inst_q <= NOP_INST;
                    up_ready_q  <= 1'b1;
                    dn_valid_q  <= 1'b0;
                    occ_q       <= 2'd0;
                end
            endcase
        end
    end

    assign up_ready_o  = up_ready_q;
    assign dn_valid_o  = dn_valid_q;
    assign dn_pc_o     = main_pc_q;
    assign dn_inst_o   = main_inst_q;
    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Drives pipe_stage_buf with directed scenarios followed by random traffic and
// compares every output each cycle against a queue model of the buffer
// contents. Inputs change on the falling edge; outputs are sampled on the
// falling edge after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int          PC_W     = 32;
    localparam int          INST_W   = 32;
    localparam logic [31:0] NOP_PC   = 32'h0;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic              clk;
    logic              rst;
    logic              flush_i;
    logic              hold_i;
    logic              up_valid_i;
    logic              up_ready_o;
    logic [PC_W-1:0]   up_pc_i;
    logic [INST_W-1:0] up_inst_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic [PC_W-1:0]   dn_pc_o;
    logic [INST_W-1:0] dn_inst_o;
    logic [1:0]        occupancy_o;

    int n_checks;
    int n_fails;

    // Model: FIFO of {pc, inst}, head is the presented entry.
    logic [63:0] mq[$];

    pipe_stage_buf #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_PC   (NOP_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_pc_i     (up_pc_i),
        .up_inst_i   (up_inst_i),
        .dn_valid_o  (dn_valid_o),
        .dn_ready_i  (dn_ready_i),
        .dn_pc_o     (dn_pc_o),
        .dn_inst_o   (dn_inst_o),
        .occupancy_o (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [63:0] head;
        head = (mq.size() > 0) ? mq[0] : {NOP_PC, NOP_INST};
        chk("occupancy", 64'(occupancy_o), 64'(mq.size()));
        chk("up_ready",  64'(up_ready_o),  64'(mq.size() < 2));
        chk("dn_valid",  64'(dn_valid_o),  64'(mq.size() > 0));
        chk("dn_pc",     64'(dn_pc_o),     64'(head[63:32]));
        chk("dn_inst",   64'(dn_inst_o),   64'(head[31:0]));
    endtask

    // One clock cycle: apply inputs at the falling edge, advance the model at
    // the rising edge, compare at the next falling edge.
    task automatic step(input logic r, input logic f, input logic h,
                        input logic uv, input logic dr,
                        input logic [31:0] pc, input logic [31:0] inst);
        bit do_push;
        bit do_pop;
        rst        = r;
        flush_i    = f;
        hold_i     = h;
        up_valid_i = uv;
        dn_ready_i = dr;
        up_pc_i    = pc;
        up_inst_i  = inst;
        do_push = uv && (mq.size() < 2);
        do_pop  = (mq.size() > 0) && dr && !h;
        #1;
        // Ready must reflect only the held count, whatever dn_ready/hold do.
        chk("ready_now", 64'(up_ready_o), 64'(mq.size() < 2));
        @(posedge clk);
        if (r || f) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({pc, inst});
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst        = 1'b1;
        flush_i    = 1'b0;
        hold_i     = 1'b0;
        up_valid_i = 1'b0;
        dn_ready_i = 1'b0;
        up_pc_i    = '0;
        up_inst_i  = '0;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1, 1, 32'hdead, 32'hbeef);
        chk("rst_inst", 64'(dn_inst_o), 64'h13);
        chk("rst_ready", 64'(up_ready_o), 64'h1);

        // Streaming with dn_ready held high
        step(0, 0, 0, 1, 1, 32'h0, 32'h1000_0001);
        chk("stream_pc0", 64'(dn_pc_o), 64'h0);
        step(0, 0, 0, 1, 1, 32'h4, 32'h1000_0002);
        chk("stream_pc4", 64'(dn_pc_o), 64'h4);
        step(0, 0, 0, 1, 1, 32'h8, 32'h1000_0003);
        chk("stream_pc8", 64'(dn_pc_o), 64'h8);
        chk("stream_occ", 64'(occupancy_o), 64'd1);
        step(0, 0, 0, 0, 1, 32'h0, 32'h0);

        // Back-pressure through hold
        step(0, 0, 1, 1, 1, 32'h10, 32'h2000_0010);
        step(0, 0, 1, 1, 1, 32'h14, 32'h2000_0014);
        chk("bp_occ", 64'(occupancy_o), 64'd2);
        chk("bp_ready", 64'(up_ready_o), 64'd0);
        step(0, 0, 1, 1, 1, 32'h18, 32'h2000_0018);  // ignored: full
        chk("bp_frozen", 64'(dn_pc_o), 64'h10);
        step(0, 0, 0, 0, 1, 32'h0, 32'h0);
        chk("bp_second", 64'(dn_pc_o), 64'h14);
        chk("bp_ready_back", 64'(up_ready_o), 64'd1);
        step(0, 0, 0, 0, 1, 32'h0, 32'h0);

        // Flush from TWO with a concurrent push and hold
        step(0, 0, 1, 1, 0, 32'h30, 32'h3000_0030);
        step(0, 0, 1, 1, 0, 32'h34, 32'h3000_0034);
        step(0, 1, 1, 1, 1, 32'h38, 32'h3000_0038);
        chk("flush_valid", 64'(dn_valid_o), 64'd0);
        chk("flush_inst", 64'(dn_inst_o), 64'h13);
        chk("flush_occ", 64'(occupancy_o), 64'd0);
        step(0, 0, 0, 0, 1, 32'h0, 32'h0);

        // Simultaneous push and pop in ONE
        step(0, 0, 0, 1, 0, 32'h20, 32'h4000_0020);
        step(0, 0, 0, 1, 1, 32'h24, 32'h4000_0024);
        chk("pp_pc", 64'(dn_pc_o), 64'h24);
        chk("pp_occ", 64'(occupancy_o), 64'd1);
        step(0, 0, 0, 0, 1, 32'h0, 32'h0);

        // Reset mid-operation from TWO
        step(0, 0, 1, 1, 0, 32'h50, 32'h5000_0050);
        step(0, 0, 1, 1, 0, 32'h54, 32'h5000_0054);
        step(1, 1, 1, 1, 1, 32'h58, 32'h5000_0058);
        chk("midrst_valid", 64'(dn_valid_o), 64'd0);
        chk("midrst_ready", 64'(up_ready_o), 64'd1);
        step(0, 0, 0, 1, 0, 32'h40, 32'h5000_0040);
        chk("midrst_first", 64'(dn_pc_o), 64'h40);
        step(0, 0, 0, 0, 1, 32'h0, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0),
                 $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
